// File: rtl/ctrl_pkg.sv
// Shared types and default constants for the run controller.
// Exports run_state_t (HALTED/RUN/STEP/DONE) and default timing parameters.
package ctrl_pkg;

    typedef enum logic [1:0] {
        HALTED = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        DONE   = 2'd3
    } run_state_t;

    // 1 ms of stable input at 100 MHz
    localparam int DEF_DEBOUNCE_CYCLES = 100_000;
    // clk cycles between cpu_en pulses while running
    localparam int DEF_RUN_DIV = 3_125_000;

endpackage

// File: rtl/run_controller_debouncer.sv
// Button conditioner: 2-flop synchronizer, debounce counter, press pulse.
// Ports: clk, rst (sync, active-low), btn_in (raw), level, press (1 cycle).
import ctrl_pkg::*;

module debouncer #(
    parameter int CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic press
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        // Counter only runs while the sample disagrees with the
        // accepted level; any agreement restarts the window.
        if (sync2_q != level_q) begin
            if (cnt_q == LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/run_controller.sv
// CPU execution controller: run/step buttons gate a 1-cycle cpu_en pulse.
// Ports: clk, rst (sync, active-low), btn_step, btn_run, cpu_halt, pc,
//        bp_addr -> cpu_en, state, cycle_count.
// Optional PC breakpoint in RUN: define RUN_CONTROLLER_BREAKPOINT_EN.
import ctrl_pkg::*;

module run_controller #(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int RUN_DIV         = DEF_RUN_DIV,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_step,
    input  logic                 btn_run,
    input  logic                 cpu_halt,
    input  logic [31:0]          pc,
    input  logic [31:0]          bp_addr,
    output logic                 cpu_en,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    localparam int DW = $clog2(RUN_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(RUN_DIV - 1);

    logic step_p, run_p;
    logic step_lvl, run_lvl;

    run_state_t           state_q, state_d;
    logic [DW-1:0]        div_q, div_d;
    logic                 cpu_en_q, cpu_en_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 bp_hit;

    debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk    (clk),
        .rst    (rst),
        .btn_in (btn_step),
        .level  (step_lvl),
        .press  (step_p)
    );

    debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_db_run (
        .clk    (clk),
        .rst    (rst),
        .btn_in (btn_run),
        .level  (run_lvl),
        .press  (run_p)
    );

`ifdef RUN_CONTROLLER_BREAKPOINT_EN
    logic armed_q, armed_d;

    // Arming waits for the first pulse so resuming at the
    // breakpoint PC does not stop again straight away.
    always_comb begin
        armed_d = armed_q;
        if (state_d == RUN && state_q != RUN) begin
            armed_d = 1'b0;
        end else if (state_q == RUN && cpu_en_q) begin
            armed_d = 1'b1;
        end
    end

    assign bp_hit = (state_q == RUN) && armed_q &&
                    !cpu_en_q && (pc == bp_addr);

    always_ff @(posedge clk) begin
        if (!rst) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= armed_d;
        end
    end
`else
    logic unused_bp;
    assign unused_bp = ^{pc, bp_addr};
    assign bp_hit    = 1'b0;
`endif

    logic unused_lvl;
    assign unused_lvl = step_lvl ^ run_lvl;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HALTED: begin
                if (run_p) begin
                    state_d = RUN;
                end else if (step_p) begin
                    state_d = STEP;
                end
            end
            RUN: begin
                if (run_p || bp_hit) begin
                    state_d = HALTED;
                end
            end
            STEP:    state_d = HALTED;
            DONE:    state_d = DONE;
            default: state_d = HALTED;
        endcase
        if (cpu_halt) begin
            state_d = DONE;
        end

        // Divider restarts on every fresh entry into RUN.
        div_d = '0;
        if (state_d == RUN && state_q == RUN) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end

        cpu_en_d = (state_d == STEP) ||
                   (state_d == RUN && div_d == DIV_LAST);

        count_d = count_q;
        if (cpu_en_q && !(&count_q)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= HALTED;
            div_q    <= '0;
            cpu_en_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            cpu_en_q <= cpu_en_d;
            count_q  <= count_d;
        end
    end

    assign cpu_en      = cpu_en_q;
    assign state       = state_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_run_controller.sv
// Scoreboard bench for run_controller with DEBOUNCE_CYCLES=4, RUN_DIV=3.
// Stimulus queues expected cpu_en pulses; a monitor checks each one.
module tb_run_controller;

    localparam int DEB = 4;
    localparam int DIV = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_step;
    logic        btn_run;
    logic        cpu_halt;
    logic [31:0] pc;
    logic [31:0] bp_addr;
    logic        cpu_en;
    logic [1:0]  state;
    logic [31:0] cycle_count;

    run_controller #(
        .DEBOUNCE_CYCLES (DEB),
        .RUN_DIV         (DIV),
        .CNT_WIDTH       (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_step    (btn_step),
        .btn_run     (btn_run),
        .cpu_halt    (cpu_halt),
        .pc          (pc),
        .bp_addr     (bp_addr),
        .cpu_en      (cpu_en),
        .state       (state),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int          at;
        logic [1:0]  st;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_cnt  = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] want);
        n_checks++;
        if (act === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     name, act, want, cyc);
        end
    endtask

    // Monitor: every cpu_en pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && cpu_en === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pulse: got cpu_en=1 want 0 (cycle %0d)",
                         cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_cycle", cyc, e.at);
                chk("pulse_state", {30'd0, state}, {30'd0, e.st});
                chk("pulse_count", cycle_count, e.cnt);
            end
        end
    end

    // CPU model: PC advances by 4 after each enable pulse.
    always @(negedge clk) begin
        if (cpu_en === 1'b1) pc = pc + 32'd4;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clean press: 8 cycles high, 8 cycles low (16 cycles total).
    task automatic press(input bit is_run);
        if (is_run) btn_run = 1'b1;
        else        btn_step = 1'b1;
        tick(8);
        btn_run  = 1'b0;
        btn_step = 1'b0;
        tick(8);
    endtask

    // Run pulses: first at N+9 (pulse at N+6, RUN at N+7, then DIV),
    // every DIV after, up to the stop press at N+16 (HALTED at N+23).
    task automatic expect_run(input int n, input int pulses);
        for (int k = 0; k < pulses; k++) begin
            q.push_back('{n + 9 + DIV * k, 2'd1, 32'(exp_cnt)});
            exp_cnt++;
        end
    endtask

    task automatic expect_step(input int n);
        q.push_back('{n + 7, 2'd2, 32'(exp_cnt)});
        exp_cnt++;
    endtask

    initial begin
        int n;
        rst      = 1'b0;
        btn_step = 1'b0;
        btn_run  = 1'b0;
        cpu_halt = 1'b0;
        pc       = 32'd0;
        bp_addr  = 32'hFFFF_FFF0;
        tick(3);
        chk("reset_cpu_en", {31'd0, cpu_en}, 32'd0);
        chk("reset_state", {30'd0, state}, 32'd0);
        chk("reset_count", cycle_count, 32'd0);
        rst = 1'b1;
        tick(2);

        // Bounce: toggle every cycle, never stable for DEB cycles.
        for (int i = 0; i < 10; i++) begin
            btn_step = ~btn_step;
            tick(1);
        end
        btn_step = 1'b0;
        tick(12);
        chk("bounce_state", {30'd0, state}, 32'd0);
        chk("bounce_count", cycle_count, 32'd0);

        // Single step twice.
        n = cyc;
        expect_step(n);
        press(1'b0);
        chk("step1_state", {30'd0, state}, 32'd0);
        chk("step1_count", cycle_count, 32'd1);
        n = cyc;
        expect_step(n);
        press(1'b0);
        chk("step2_count", cycle_count, 32'd2);

        // Run then pause: pulses at N+9..N+21.
        n = cyc;
        expect_run(n, 5);
        press(1'b1);
        chk("run_state", {30'd0, state}, 32'd1);
        press(1'b1);
        chk("pause_state", {30'd0, state}, 32'd0);
        chk("pause_count", cycle_count, 32'(exp_cnt));

        // Halt while running: pulses at N+9 and N+12 only.
        n = cyc;
        expect_run(n, 2);
        btn_run = 1'b1;
        tick(8);
        btn_run = 1'b0;
        tick(5);
        cpu_halt = 1'b1;
        tick(1);
        cpu_halt = 1'b0;
        chk("halt_state", {30'd0, state}, 32'd3);
        tick(10);
        press(1'b1);
        press(1'b0);
        chk("done_sticky_state", {30'd0, state}, 32'd3);
        chk("done_count", cycle_count, 32'(exp_cnt));

        rst = 1'b0;
        tick(3);
        chk("rst2_state", {30'd0, state}, 32'd0);
        chk("rst2_count", cycle_count, 32'd0);
        rst = 1'b1;
        exp_cnt = 0;
        tick(2);

`ifdef RUN_CONTROLLER_BREAKPOINT_EN
        pc      = 32'd0;
        bp_addr = 32'h10;
        // Four pulses take pc 0 -> 0x10, then HALTED at N+20.
        n = cyc;
        expect_run(n, 4);
        press(1'b1);
        tick(8);
        chk("bp_state", {30'd0, state}, 32'd0);
        chk("bp_count", cycle_count, 32'd4);
        chk("bp_pc", pc, 32'h10);
        // Resume from the breakpoint PC without re-halting.
        n = cyc;
        expect_run(n, 5);
        press(1'b1);
        chk("bp_resume_state", {30'd0, state}, 32'd1);
        press(1'b1);
        chk("bp_pause_state", {30'd0, state}, 32'd0);
        chk("bp_resume_count", cycle_count, 32'd9);
`endif

        tick(5);
        chk("pending_pulses", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
